// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART echo core.
// Imported by uart_fifo_sync and uart_echo_fifo.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers for the UART echo path.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
module uart_fifo_sync
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             wr, rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign wr = push_i & ~full_o;
  assign rd = pop_i & ~empty_o;

  assign wptr_d = wr ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = rd ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo core: oversampled RX, FIFO buffer, TX with hold and sticky errors.
// Define UART_ECHO_STATS_EN to add 16-bit rx_count/tx_count outputs.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 42000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        tx,
  input  logic                        tx_hold,
  input  logic                        err_clr,
  output logic                        rx_busy,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        parity_err
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]                 rx_count,
  output logic [15:0]                 tx_count
`endif
);

  localparam int DIV_R = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W     = DATA_BITS;
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);
  localparam logic [4:0] STOP_END = 5'(STOP_BITS * OVERSAMPLE - 1);

  logic [CW-1:0] tcnt_q;
  logic          tick;

  assign tick = (tcnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
  end

  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  rx_state_e     rx_st_q;
  logic [3:0]    rx_stk_q;
  logic [3:0]    rx_bit_q;
  logic [W-1:0]  rx_sh_q;
  logic          rx_pbad_q;
  logic          rx_samp, rx_par_exp;
  logic          stop_samp, push_req, push;

  assign rx_samp    = tick && (rx_stk_q == 4'd15);
  assign rx_par_exp = (PARITY == PARITY_ODD) ? ~^rx_sh_q : ^rx_sh_q;
  assign stop_samp  = (rx_st_q == RX_STOP) && rx_samp;
  assign push_req   = stop_samp && rx_s && !rx_pbad_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q   <= RX_IDLE;
      rx_stk_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_pbad_q <= 1'b0;
    end else begin
      if (tick) rx_stk_q <= rx_stk_q + 4'd1;
      unique case (rx_st_q)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_st_q  <= RX_START;
            rx_stk_q <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit check filters glitches shorter than half a bit
          if (tick && rx_stk_q == 4'd7) begin
            rx_stk_q  <= '0;
            rx_bit_q  <= '0;
            rx_pbad_q <= 1'b0;
            rx_st_q   <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_samp) begin
            rx_sh_q  <= {rx_s, rx_sh_q[W-1:1]};
            rx_bit_q <= rx_bit_q + 4'd1;
            if (rx_bit_q == 4'(W - 1))
              rx_st_q <= HAS_PAR ? RX_PAR : RX_STOP;
          end
        end
        RX_PAR: begin
          if (rx_samp) begin
            rx_pbad_q <= (rx_s != rx_par_exp);
            rx_st_q   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_samp) rx_st_q <= rx_s ? RX_IDLE : RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_s) rx_st_q <= RX_IDLE;
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  logic [W-1:0] f_rdata;
  logic         f_empty, f_full, pop;

  assign push = push_req & ~f_full;

  uart_fifo_sync #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rx_sh_q),
    .pop_i   (pop),
    .rdata_o (f_rdata),
    .empty_o (f_empty),
    .full_o  (f_full),
    .count_o (fifo_count)
  );

  logic ovf_q, ovf_d;
  logic fe_q, fe_d;
  logic pe_q, pe_d;

  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | (push_req & f_full);
    fe_d  = (fe_q & ~err_clr) | (stop_samp & ~rx_s);
    pe_d  = (pe_q & ~err_clr) | (stop_samp & rx_s & rx_pbad_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      fe_q  <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      fe_q  <= fe_d;
      pe_q  <= pe_d;
    end
  end

  tx_state_e    tx_st_q;
  logic [4:0]   tx_stk_q;
  logic [3:0]   tx_bit_q;
  logic [W-1:0] tx_sh_q;
  logic         tx_par_q;
  logic         tx_q;
  logic         tx_bit_end, tx_done;

  assign pop        = (tx_st_q == TX_IDLE) && !f_empty && !tx_hold;
  assign tx_bit_end = tick && (tx_stk_q == 5'd15);
  assign tx_done    = (tx_st_q == TX_STOP) && tick && (tx_stk_q == STOP_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_stk_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      unique case (tx_st_q)
        TX_IDLE: begin
          if (pop) begin
            tx_sh_q  <= f_rdata;
            tx_par_q <= (PARITY == PARITY_ODD) ? ~^f_rdata : ^f_rdata;
            tx_q     <= 1'b0;
            tx_stk_q <= '0;
            tx_st_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_stk_q <= '0;
            tx_bit_q <= '0;
            tx_st_q  <= TX_DATA;
          end else if (tick) begin
            tx_stk_q <= tx_stk_q + 5'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_stk_q <= '0;
            if (tx_bit_q == 4'(W - 1)) begin
              tx_q    <= HAS_PAR ? tx_par_q : 1'b1;
              tx_st_q <= HAS_PAR ? TX_PAR : TX_STOP;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else if (tick) begin
            tx_stk_q <= tx_stk_q + 5'd1;
          end
        end
        TX_PAR: begin
          if (tx_bit_end) begin
            tx_q     <= 1'b1;
            tx_stk_q <= '0;
            tx_st_q  <= TX_STOP;
          end else if (tick) begin
            tx_stk_q <= tx_stk_q + 5'd1;
          end
        end
        TX_STOP: begin
          if (tx_done)   tx_st_q  <= TX_IDLE;
          else if (tick) tx_stk_q <= tx_stk_q + 5'd1;
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_ECHO_STATS_EN
  logic [15:0] rxc_q, txc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxc_q <= '0;
      txc_q <= '0;
    end else begin
      if (push)    rxc_q <= rxc_q + 16'd1;
      if (tx_done) txc_q <= txc_q + 16'd1;
    end
  end

  assign rx_count = rxc_q;
  assign tx_count = txc_q;
`endif

  assign tx         = tx_q;
  assign rx_busy    = (rx_st_q != RX_IDLE);
  assign tx_busy    = (tx_st_q != TX_IDLE);
  assign overflow   = ovf_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: 8N1 instance plus an even-parity one.
// DIV=1, so one bit on the line lasts 16 clocks.
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rxp = 1'b1;
  logic       tx_hold = 1'b0, err_clr = 1'b0;
  logic       tx, txp;
  logic       rx_busy, tx_busy, rx_busy_p, tx_busy_p;
  logic [2:0] cnt, cnt_p;
  logic       ovf, fe, pe, ovf_p, fe_p, pe_p;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rxc, txc, rxc_p, txc_p;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_fifo #(
    .CLOCK_RATE(16000000), .BAUD_RATE(1000000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .tx_hold(tx_hold), .err_clr(err_clr),
    .rx_busy(rx_busy), .tx_busy(tx_busy), .fifo_count(cnt),
    .overflow(ovf), .frame_err(fe), .parity_err(pe)
`ifdef UART_ECHO_STATS_EN
    , .rx_count(rxc), .tx_count(txc)
`endif
  );

  uart_echo_fifo #(
    .CLOCK_RATE(16000000), .BAUD_RATE(1000000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dutp (
    .clk(clk), .rst(rst), .rx(rxp), .tx(txp),
    .tx_hold(1'b0), .err_clr(err_clr),
    .rx_busy(rx_busy_p), .tx_busy(tx_busy_p), .fifo_count(cnt_p),
    .overflow(ovf_p), .frame_err(fe_p), .parity_err(pe_p)
`ifdef UART_ECHO_STATS_EN
    , .rx_count(rxc_p), .tx_count(txc_p)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic line(input bit sel);
    return sel ? txp : tx;
  endfunction

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rxp = v;
    else     rx  = v;
  endtask

  task automatic send(input bit sel, input logic [11:0] fr, input int len);
    for (int i = 0; i < len; i++) begin
      set_rx(sel, fr[i]);
      tick_n(16);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic wait_fall(input bit sel, input int lim, output int tf);
    int n = 0;
    while (line(sel) !== 1'b0 && n < lim) begin
      tick_n(1);
      n++;
    end
    tf = cyc;
    chk("tx_fall", line(sel), 1'b0);
  endtask

  task automatic cap(input bit sel, input int nb,
                     output logic [8:0] d, output int tf);
    d = '0;
    wait_fall(sel, 800, tf);
    tick_n(8);
    chk("start_mid", line(sel), 1'b0);
    for (int i = 0; i < nb; i++) begin
      tick_n(16);
      d[i] = line(sel);
    end
    tick_n(16);
    chk("stop_mid", line(sel), 1'b1);
  endtask

  logic [8:0] d;
  int         c0, tf, tprev, tcnt;
  bit         seen;

  initial begin
    // Reset state
    tick_n(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rxb", rx_busy, 1'b0);
    chk("rst_txb", tx_busy, 1'b0);
    chk("rst_cnt", cnt, 3'd0);
    chk("rst_flags", {ovf, fe, pe, ovf_p, fe_p, pe_p}, 6'd0);
    chk("rst_txp", txp, 1'b1);
    rst = 1'b0;
    tick_n(5);

    // 1: echo 0x55 and latency
    c0 = cyc;
    tcnt = -1;
    fork
      send(1'b0, {1'b1, 8'h55, 1'b0}, 10);
      cap(1'b0, 8, d, tf);
      begin
        for (int n = 0; n < 400 && cnt == 3'd0; n++) tick_n(1);
        tcnt = cyc;
      end
    join
    chk("t1_data", d, 9'h055);
    chk("t1_lat_abs", tf - c0, 156);
    chk("t1_lat_push", tf - tcnt, 1);
    tick_n(20);
    chk("t1_cnt", cnt, 3'd0);
    chk("t1_txb", tx_busy, 1'b0);

    // 2: hold, fill past depth, release
    tx_hold = 1'b1;
    for (int i = 1; i <= 5; i++) send(1'b0, {1'b1, 8'(i), 1'b0}, 10);
    tick_n(4);
    chk("t2_cnt", cnt, 3'd4);
    chk("t2_ovf", ovf, 1'b1);
    chk("t2_tx_held", tx, 1'b1);
    tx_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cap(1'b0, 8, d, tf);
      chk("t2_data", d, 9'(i));
      if (i > 1) chk("t2_b2b", tf - tprev, 161);
      tprev = tf;
    end
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (tx == 1'b0) seen = 1'b1;
      tick_n(1);
    end
    chk("t2_no_fifth", seen, 1'b0);
    chk("t2_cnt_end", cnt, 3'd0);

    // 3: framing error
    send(1'b0, {1'b0, 8'hA3, 1'b0}, 10);
    tick_n(4);
    chk("t3_fe", fe, 1'b1);
    chk("t3_cnt", cnt, 3'd0);
    chk("t3_tx", tx, 1'b1);
    chk("t3_txb", tx_busy, 1'b0);
    chk("t3_rxb", rx_busy, 1'b0);
    err_clr = 1'b1;
    tick_n(1);
    err_clr = 1'b0;
    tick_n(1);
    chk("t3_fe_clr", fe, 1'b0);
    chk("t3_ovf_clr", ovf, 1'b0);

    // 4: even parity instance
    send(1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    tick_n(4);
    chk("t4_pe", pe_p, 1'b1);
    chk("t4_cnt", cnt_p, 3'd0);
    chk("t4_txp_idle", tx_busy_p, 1'b0);
    fork
      send(1'b1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
      cap(1'b1, 9, d, tf);
    join
    chk("t4_echo", d, 9'h107);

    // 5: short glitch
    seen = 1'b0;
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (rx_busy) seen = 1'b1;
      tick_n(1);
    end
    chk("t5_busy_pulse", seen, 1'b1);
    chk("t5_rxb", rx_busy, 1'b0);
    chk("t5_cnt", cnt, 3'd0);
    chk("t5_flags", {ovf, fe, pe}, 3'd0);

    // 6: reset mid-frame
    tx_hold = 1'b1;
    send(1'b0, {1'b1, 8'h81, 1'b0}, 10);
    send(1'b0, {1'b1, 8'h42, 1'b0}, 10);
    tx_hold = 1'b0;
    wait_fall(1'b0, 50, tf);
    tick_n(40);
    chk("t6_cnt_pre", cnt, 3'd1);
    rst = 1'b1;
    #1;
    chk("t6_tx_async", tx, 1'b1);
    chk("t6_txb", tx_busy, 1'b0);
    chk("t6_cnt", cnt, 3'd0);
    chk("t6_flags", {ovf, fe, pe}, 3'd0);
    tick_n(2);
    rst = 1'b0;
    tick_n(3);
    fork
      send(1'b0, {1'b1, 8'h3C, 1'b0}, 10);
      cap(1'b0, 8, d, tf);
    join
    chk("t6_echo", d, 9'h03C);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (tx == 1'b0) seen = 1'b1;
      tick_n(1);
    end
    chk("t6_no_stale", seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
